dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
Data-memory responder serving the CPU's load/store port (address from ALU result, write data from busB, write enable from MemWr, read data to the MemToReg mux).
- Adds a valid/ready request handshake and a fixed, parameterised wait-state latency, so the datapath can be run against slow memory.
- Word-addressed storage; misaligned and out-of-range accesses are flagged rather than executed.

Parameters:
- DEPTH_LOG2, 10, log2 of the number of 32-bit words stored (1024 words).
- WAIT_CYCLES, 2, wait states between request acceptance and response; legal range 0..15.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  CPU presents a request.
- req_wr  in  1  1 = store (sw), 0 = load (lw).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_ready  out  1  responder can accept a request this cycle.
- rsp_valid  out  1  single-cycle pulse; response fields valid.
- rsp_rdata  out  32  load data; 0 for stores and errors.
- rsp_err  out  1  access was misaligned or out of range.

Behaviour:
- Reset (async, active-high): state IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0, latched request registers=0. Memory contents are not reset.
- States: IDLE, WAIT, RESP, 2-bit encoding.
- IDLE:
  - req_ready=1.
  - Accept on the edge where req_valid=1: latch wr, addr and wdata; load counter with WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES>0, else RESP.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle.
  - When counter==1, next state is RESP.
- Edge entering RESP:
  - Error check: err = (addr[1:0]!=0) or (addr[31:DEPTH_LOG2+2]!=0).
  - Store without error: mem[addr[DEPTH_LOG2+1:2]] <= wdata.
  - Load without error: rsp_rdata <= mem[index].
  - Otherwise rsp_rdata <= 0.
  - rsp_err <= err.
- RESP:
  - rsp_valid=1 for exactly one cycle; req_ready=0; next state IDLE.
  - No response backpressure; the CPU must sample rsp_valid.
  - rsp_rdata and rsp_err hold their values until the next RESP entry.
- Latency: acceptance edge to rsp_valid high = WAIT_CYCLES+1 cycles. Peak throughput is one request per WAIT_CYCLES+2 cycles.
- Request inputs are ignored while req_ready=0; no queueing.
- Load immediately after a store to the same word returns the new data, because the write committed on the earlier RESP entry edge.
- Reset mid-operation: transaction abandoned, no rsp_valid.
  - A store is committed only if its RESP entry edge occurred before reset assertion.
- An error access never modifies memory.

Optional Feature:
DMEM_STALL_CNT_EN
- Defined: adds output stall_cnt (32 bits).
  - Increments on every cycle with req_valid=1 and req_ready=0.
  - Saturates at 0xFFFFFFFF.
  - Cleared by rst.
- Not defined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package/include dmem_pkg holds:
  - state encodings: IDLE=2'd0, WAIT=2'd1, RESP=2'd2;
  - ADDR_LSB=2;
  - the word-index width expression;
  - counter width=4.
- Sub-module dmem_array:
  - DEPTH words × 32;
  - synchronous write with enable;
  - registered read, with read/write on the same edge;
  - no reset.
- FSM, counter and error check remain in dmem_responder.

Test Plan:
- Store 0xDEADBEEF to 0x00000010, then load 0x10 with WAIT_CYCLES=2 -> rsp_valid 3 cycles after each accept; load rsp_rdata=0xDEADBEEF, rsp_err=0.
- Load 0x00000012 (misaligned) -> rsp_err=1, rsp_rdata=0; a store to 0x12 leaves word 4 unchanged.
- Store to 0x00001000 (DEPTH_LOG2=10, out of range) -> rsp_err=1; a later load of 0x0 returns the prior contents of word 0.
- WAIT_CYCLES=0: back-to-back requests -> req_ready pattern 1,0,1,0; rsp_valid one cycle after each accept.
- Assert rst during WAIT of a store to 0x20 -> outputs return to reset values immediately; a later load of 0x20 returns the old data; no rsp_valid is produced.
- With DMEM_STALL_CNT_EN: hold req_valid high across 3 transactions at WAIT_CYCLES=2 -> stall_cnt=9.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory responder.
//   - state_e  : responder FSM encoding (IDLE, WAIT, RESP)
//   - ADDR_LSB : number of byte-offset bits below the word index
//   - CNT_W    : wait-state counter width (holds 0..15)
//   - idx_width: word-index width for a given log2 depth
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int ADDR_LSB = 2;
  localparam int CNT_W    = 4;

  // Word index width: one index bit per power of two of stored words.
  function automatic int idx_width(input int depth_log2);
    return depth_log2;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port word memory, 2**DEPTH_LOG2 words x 32 bits.
// Synchronous write with enable, registered read with enable; a read and a
// write on the same edge return the previous contents. Not reset.
// Ports:
//   clk   in   clock
//   we    in   write enable
//   re    in   read enable (rdata updates only when set)
//   addr  in   word index
//   wdata in   write data
//   rdata out  registered read data, held between reads
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                                   clk,
  input  logic                                   we,
  input  logic                                   re,
  input  logic [idx_width(DEPTH_LOG2)-1:0]       addr,
  input  logic [31:0]                            wdata,
  output logic [31:0]                            rdata
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [31:0] mem_r [DEPTH];
  logic [31:0] rdata_r;

  // Write port and registered read port sharing one address.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
    if (re) begin
      rdata_r <= mem_r[addr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the CPU load/store port.
// Accepts one request at a time over a valid/ready handshake, waits
// WAIT_CYCLES cycles, then performs the access and pulses rsp_valid.
// Misaligned or out-of-range addresses are flagged and never executed.
// Optional build macro: DMEM_STALL_CNT_EN adds the stall_cnt output.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   req_valid  in   request present
//   req_wr     in   1 = store, 0 = load
//   req_addr   in   byte address
//   req_wdata  in   store data
//   req_ready  out  request can be accepted this cycle
//   rsp_valid  out  one-cycle response pulse
//   rsp_rdata  out  load data (0 for stores and errors)
//   rsp_err    out  misaligned or out-of-range access
//   stall_cnt  out  (DMEM_STALL_CNT_EN only) saturating count of cycles
//                   with req_valid high while req_ready is low
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_wr,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
`ifdef DMEM_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  localparam int               IDX_W     = idx_width(DEPTH_LOG2);
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);

  state_e             state_r;
  state_e             state_next_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_next_s;
  logic               accept_s;

  logic               wr_r;
  logic [31:0]        addr_r;
  logic [31:0]        wdata_r;

  logic               acc_wr_s;
  logic [31:0]        acc_addr_s;
  logic [31:0]        acc_wdata_s;
  logic               err_s;
  logic               resp_entry_s;
  logic               mem_we_s;
  logic               mem_re_s;
  logic [IDX_W-1:0]   mem_idx_s;
  logic [31:0]        arr_rdata_s;

  logic               req_ready_r;
  logic               rsp_valid_r;
  logic               rsp_err_r;
  logic               load_ok_r;

  // Next-state and wait-counter logic.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    accept_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          accept_s   = 1'b1;
          cnt_next_s = WAIT_LOAD;
          if (WAIT_LOAD != {CNT_W{1'b0}}) begin
            state_next_s = WAIT;
          end else begin
            state_next_s = RESP;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      WAIT: begin
        // <= also catches an impossible zero count so WAIT cannot hang.
        if (cnt_r <= 4'd1) begin
          state_next_s = RESP;
          cnt_next_s   = {CNT_W{1'b0}};
        end else begin
          state_next_s = WAIT;
          cnt_next_s   = cnt_r - 4'd1;
        end
      end
      RESP: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
        cnt_next_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Access decode: with zero wait states RESP is entered on the accept edge,
  // before the request is latched, so the live request is used in IDLE.
  always_comb begin
    if (state_r == IDLE) begin
      acc_wr_s    = req_wr;
      acc_addr_s  = req_addr;
      acc_wdata_s = req_wdata;
    end else begin
      acc_wr_s    = wr_r;
      acc_addr_s  = addr_r;
      acc_wdata_s = wdata_r;
    end
    err_s        = (acc_addr_s[ADDR_LSB-1:0] != 2'b00) ||
                   ((acc_addr_s >> (DEPTH_LOG2 + ADDR_LSB)) != 32'd0);
    resp_entry_s = (state_next_s == RESP) && (state_r != RESP);
    mem_we_s     = resp_entry_s && acc_wr_s && !err_s;
    mem_re_s     = resp_entry_s && !acc_wr_s && !err_s;
    mem_idx_s    = acc_addr_s[DEPTH_LOG2+ADDR_LSB-1:ADDR_LSB];
  end

  // FSM state and wait counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Latched request, captured on acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_r    <= 1'b0;
      addr_r  <= 32'd0;
      wdata_r <= 32'd0;
    end else if (accept_s) begin
      wr_r    <= req_wr;
      addr_r  <= req_addr;
      wdata_r <= req_wdata;
    end
  end

  // Handshake and response flags; rsp_err and load_ok hold until next RESP entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      load_ok_r   <= 1'b0;
    end else begin
      req_ready_r <= (state_next_s == IDLE);
      rsp_valid_r <= (state_next_s == RESP);
      if (resp_entry_s) begin
        rsp_err_r <= err_s;
        load_ok_r <= mem_re_s;
      end
    end
  end

  dmem_array #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk   (clk),
    .we    (mem_we_s),
    .re    (mem_re_s),
    .addr  (mem_idx_s),
    .wdata (acc_wdata_s),
    .rdata (arr_rdata_s)
  );

  // The array read register is not reset and is only refreshed by good
  // loads, so a registered qualifier zeroes the data for stores/errors/reset.
  assign rsp_rdata = load_ok_r ? arr_rdata_s : 32'd0;
  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_err   = rsp_err_r;

`ifdef DMEM_STALL_CNT_EN
  logic [31:0] stall_cnt_r;

  // Saturating count of cycles where a request waits on a busy responder.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= 32'd0;
    end else if (req_valid && !req_ready_r && (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: one instance with 2 wait states (a) and one
// with 0 wait states (b), directed steps followed by random transactions
// compared against a word-level reference memory.
module tb_dmem_responder;

  localparam int DL2 = 10;
  localparam int WA  = 2;
  localparam int WB  = 0;

  logic        clk = 1'b0;
  logic        rst;

  logic        a_valid, a_wr, a_ready, a_rvalid, a_err;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic        b_valid, b_wr, b_ready, b_rvalid, b_err;
  logic [31:0] b_addr, b_wdata, b_rdata;
`ifdef DMEM_STALL_CNT_EN
  logic [31:0] a_stall, b_stall;
`endif

  int vectors     = 0;
  int miscompares = 0;
  logic [31:0] ref_mem [int];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_LOG2(DL2), .WAIT_CYCLES(WA)) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(a_valid), .req_wr(a_wr), .req_addr(a_addr), .req_wdata(a_wdata),
    .req_ready(a_ready), .rsp_valid(a_rvalid), .rsp_rdata(a_rdata), .rsp_err(a_err)
`ifdef DMEM_STALL_CNT_EN
    , .stall_cnt(a_stall)
`endif
  );

  dmem_responder #(.DEPTH_LOG2(DL2), .WAIT_CYCLES(WB)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(b_valid), .req_wr(b_wr), .req_addr(b_addr), .req_wdata(b_wdata),
    .req_ready(b_ready), .rsp_valid(b_rvalid), .rsp_rdata(b_rdata), .rsp_err(b_err)
`ifdef DMEM_STALL_CNT_EN
    , .stall_cnt(b_stall)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int which, input logic v, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wdata);
    if (which == 0) begin
      a_valid = v; a_wr = wr; a_addr = addr; a_wdata = wdata;
    end else begin
      b_valid = v; b_wr = wr; b_addr = addr; b_wdata = wdata;
    end
  endtask

  function automatic logic ready_of(input int which);
    return (which == 0) ? a_ready : b_ready;
  endfunction
  function automatic logic rvalid_of(input int which);
    return (which == 0) ? a_rvalid : b_rvalid;
  endfunction
  function automatic logic err_of(input int which);
    return (which == 0) ? a_err : b_err;
  endfunction
  function automatic logic [31:0] rdata_of(input int which);
    return (which == 0) ? a_rdata : b_rdata;
  endfunction
  function automatic int wait_of(input int which);
    return (which == 0) ? WA : WB;
  endfunction

  // Reference rules: word aligned and below 4 * 2**DL2 bytes, else an error.
  function automatic logic model_err(input logic [31:0] addr);
    return (addr % 4 != 0) || (addr >= (32'd4 << DL2));
  endfunction
  function automatic int model_key(input int which, input logic [31:0] addr);
    return which * (1 << DL2) + int'(addr / 4);
  endfunction

  // One complete transaction with valid dropped right after acceptance.
  task automatic txn(input int which, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wdata);
    int          lat;
    int          k;
    logic        e;
    logic        known;
    logic [31:0] exp_d;
    e     = model_err(addr);
    k     = e ? -1 : model_key(which, addr);
    known = 1'b1;
    exp_d = 32'd0;
    if (!wr && !e) begin
      if (ref_mem.exists(k)) exp_d = ref_mem[k];
      else known = 1'b0;
    end
    @(negedge clk);
    chk($sformatf("ready_idle[%0d]", which), {31'd0, ready_of(which)}, 32'd1);
    set_req(which, 1'b1, wr, addr, wdata);
    @(posedge clk);
    @(negedge clk);
    set_req(which, 1'b0, 1'b0, 32'd0, 32'd0);
    lat = 1;
    while (!rvalid_of(which) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk($sformatf("latency[%0d] a=%08h", which, addr), 32'(lat), 32'(wait_of(which) + 1));
    chk($sformatf("rsp_err[%0d] a=%08h", which, addr), {31'd0, err_of(which)}, {31'd0, e});
    if (known) chk($sformatf("rsp_rdata[%0d] a=%08h", which, addr), rdata_of(which), exp_d);
    @(negedge clk);
    chk($sformatf("rsp_pulse[%0d]", which), {31'd0, rvalid_of(which)}, 32'd0);
    if (wr && !e) ref_mem[k] = wdata;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_a_ready"},  {31'd0, a_ready},  32'd1);
    chk({tag, "_a_rvalid"}, {31'd0, a_rvalid}, 32'd0);
    chk({tag, "_a_rdata"},  a_rdata,           32'd0);
    chk({tag, "_a_err"},    {31'd0, a_err},    32'd0);
    chk({tag, "_b_ready"},  {31'd0, b_ready},  32'd1);
    chk({tag, "_b_rdata"},  b_rdata,           32'd0);
  endtask

  initial begin
    int n;
    int cyc;
    int sel;
    logic [31:0] ra;

    rst = 1'b1;
    set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
`ifdef DMEM_STALL_CNT_EN
    chk("reset_stall", a_stall, 32'd0);
`endif
    rst = 1'b0;

    // Store then load, 2 wait states.
    txn(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    txn(0, 1'b0, 32'h0000_0010, 32'd0);

    // Misaligned load and store; word 4 must survive.
    txn(0, 1'b0, 32'h0000_0012, 32'd0);
    txn(0, 1'b1, 32'h0000_0012, 32'h1234_5678);
    txn(0, 1'b0, 32'h0000_0010, 32'd0);

    // Out-of-range store aliases word 0 in the low bits; must not write it.
    txn(0, 1'b1, 32'h0000_0000, 32'hA5A5_0001);
    txn(0, 1'b1, 32'h0000_1000, 32'hFFFF_0000);
    txn(0, 1'b0, 32'h0000_0000, 32'd0);
    txn(0, 1'b0, 32'h8000_0000, 32'd0);

    // Reset during WAIT of a store.
    txn(0, 1'b1, 32'h0000_0020, 32'h0BAD_0020);
    txn(0, 1'b0, 32'h0000_0010, 32'd0);
    @(negedge clk);
    set_req(0, 1'b1, 1'b1, 32'h0000_0020, 32'h600D_0020);
    @(posedge clk);
    @(negedge clk);
    set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("in_wait_ready", {31'd0, a_ready}, 32'd0);
    rst = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    repeat (2) begin
      @(negedge clk);
      chk("midrst_no_rsp", {31'd0, a_rvalid}, 32'd0);
    end
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_no_rsp", {31'd0, a_rvalid}, 32'd0);
    end
    txn(0, 1'b0, 32'h0000_0020, 32'd0);

    // Hold req_valid across three loads: one accept per 4 cycles.
`ifdef DMEM_STALL_CNT_EN
    chk("stall_before_hold", a_stall, 32'd0);
`endif
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 32'h0000_0010, 32'd0);
    n   = 0;
    cyc = 0;
    while (n < 3 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (a_rvalid) begin
        n++;
        chk("held_rdata", a_rdata, 32'hDEAD_BEEF);
      end
    end
    chk("held_count", 32'(n), 32'd3);
    chk("held_cycles", 32'(cyc), 32'(3 * (WA + 2) - 1));
    @(posedge clk);
    #1;
    set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
`ifdef DMEM_STALL_CNT_EN
    chk("stall_cnt", a_stall, 32'd9);
`endif

    // Zero wait states, back-to-back: ready 1,0,1,0 and rsp one cycle later.
    txn(1, 1'b1, 32'h0000_0040, 32'hCAFE_0040);
    @(negedge clk);
    set_req(1, 1'b1, 1'b0, 32'h0000_0040, 32'd0);
    chk("b2b_ready0", {31'd0, b_ready}, 32'd1);
    chk("b2b_rv0",    {31'd0, b_rvalid}, 32'd0);
    @(negedge clk);
    chk("b2b_ready1", {31'd0, b_ready}, 32'd0);
    chk("b2b_rv1",    {31'd0, b_rvalid}, 32'd1);
    chk("b2b_data1",  b_rdata, 32'hCAFE_0040);
    @(negedge clk);
    chk("b2b_ready2", {31'd0, b_ready}, 32'd1);
    chk("b2b_rv2",    {31'd0, b_rvalid}, 32'd0);
    @(negedge clk);
    chk("b2b_ready3", {31'd0, b_ready}, 32'd0);
    chk("b2b_rv3",    {31'd0, b_rvalid}, 32'd1);
    set_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    chk("b2b_ready4", {31'd0, b_ready}, 32'd1);
    txn(1, 1'b1, 32'h0000_0044, 32'h0000_0001);
    txn(1, 1'b0, 32'h0000_0044, 32'd0);
    txn(1, 1'b1, 32'h0000_0047, 32'h0000_0002);
    txn(1, 1'b0, 32'h0000_0044, 32'd0);

    // Random traffic on both instances.
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7)       ra = 32'($urandom_range(0, 15)) * 32'd4;
      else if (sel == 7) ra = 32'($urandom_range(0, 15)) * 32'd4 + 32'($urandom_range(1, 3));
      else if (sel == 8) ra = 32'h0000_1000 + 32'($urandom_range(0, 15)) * 32'd4;
      else               ra = $urandom;
      txn($urandom_range(0, 1), 1'($urandom_range(0, 1)), ra, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
